// File: rtl/video_mode_ctrl.sv
// Frame-synchronous mode controller for the video mux background select.
// Mode requests are latched at any time and committed only on a frame_start pulse, followed by optional blanking.
module video_mode_ctrl #(
  parameter int BLANK_FRAMES       = 2,
  parameter int AUTO_PERIOD_FRAMES = 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_pulse_in,
  input  logic       sw_direct_in,
  input  logic [1:0] sw_mode_in,
  input  logic       frame_start_in,
  input  logic       camera_locked_in,
  output logic [1:0] bg_out,
  output logic       blank_out,
  output logic       pending_out,
  output logic       mode_changed_out,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_STABLE  = 2'd0,
    ST_PENDING = 2'd1,
    ST_BLANK   = 2'd2
  } state_t;

  localparam bit          AUTO_EN    = (AUTO_PERIOD_FRAMES > 0);
  localparam bit          BLANK_EN   = (BLANK_FRAMES > 0);
  localparam logic [15:0] AUTO_LAST  = 16'(AUTO_PERIOD_FRAMES - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_FRAMES - 1);

  state_t      state;
  logic [1:0]  target;
  logic [15:0] auto_cnt;
  logic [15:0] blank_cnt;

  logic        auto_expire;
  logic        manual_req;
  logic        commit;
  logic [1:0]  ref_bg;
  logic [1:0]  base;
  logic [1:0]  manual_next;
  logic        nxt_pend;
  logic [1:0]  nxt_tgt;

  assign state_dbg = state;

  // Request evaluation. ref_bg is the mode that will be on the mux after this
  // cycle, so a request coincident with a commit is judged against the new mode.
  always_comb begin
    auto_expire = AUTO_EN && (state == ST_STABLE) && !sw_direct_in &&
                  frame_start_in && (auto_cnt == AUTO_LAST);
    manual_req  = !sw_direct_in && (btn_pulse_in || auto_expire);
    commit      = (state == ST_PENDING) && frame_start_in &&
                  ((target == 2'd0) || camera_locked_in);
    ref_bg      = commit ? target : bg_out;
    base        = pending_out ? target : bg_out;
    manual_next = base + 2'd1;
    if (!camera_locked_in) begin
      manual_next = 2'd0;
    end

    nxt_pend = commit ? 1'b0 : pending_out;
    nxt_tgt  = target;
    if (!camera_locked_in && (ref_bg != 2'd0)) begin
      nxt_pend = 1'b1;
      nxt_tgt  = 2'd0;
    end else if (sw_direct_in) begin
      // Direct mode owns the target outright; a matching switch cancels any pending change.
      if (sw_mode_in != ref_bg) begin
        nxt_pend = 1'b1;
        nxt_tgt  = sw_mode_in;
      end else begin
        nxt_pend = 1'b0;
      end
    end else if (manual_req) begin
      if (manual_next != ref_bg) begin
        nxt_pend = 1'b1;
        nxt_tgt  = manual_next;
      end else begin
        nxt_pend = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_STABLE;
      target           <= 2'd0;
      bg_out           <= 2'd0;
      blank_out        <= 1'b0;
      pending_out      <= 1'b0;
      mode_changed_out <= 1'b0;
      auto_cnt         <= 16'd0;
      blank_cnt        <= 16'd0;
    end else begin
      pending_out      <= nxt_pend;
      target           <= nxt_tgt;
      mode_changed_out <= commit;

      // Auto-cycle frame counter only runs while idle in manual mode.
      if ((state != ST_STABLE) || sw_direct_in || btn_pulse_in || auto_expire) begin
        auto_cnt <= 16'd0;
      end else if (frame_start_in) begin
        auto_cnt <= auto_cnt + 16'd1;
      end

      if (commit) begin
        bg_out    <= target;
        blank_cnt <= 16'd0;
        if (BLANK_EN) begin
          blank_out <= 1'b1;
          state     <= ST_BLANK;
        end else begin
          state <= nxt_pend ? ST_PENDING : ST_STABLE;
        end
      end else begin
        case (state)
          ST_STABLE: begin
            if (nxt_pend) begin
              state <= ST_PENDING;
            end
          end
          ST_PENDING: begin
            if (!nxt_pend) begin
              state <= ST_STABLE;
            end
          end
          ST_BLANK: begin
            // The frame that ends blanking never commits; a latched request waits one more frame.
            if (frame_start_in) begin
              if (blank_cnt == BLANK_LAST) begin
                blank_out <= 1'b0;
                blank_cnt <= 16'd0;
                state     <= nxt_pend ? ST_PENDING : ST_STABLE;
              end else begin
                blank_cnt <= blank_cnt + 16'd1;
              end
            end
          end
          default: begin
            state <= ST_STABLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: a blanking instance (BLANK_FRAMES=2) and an auto-cycle instance.
module tb_video_mode_ctrl;

  logic       clk;
  int         checks;
  int         failures;

  // Instance A: BLANK_FRAMES=2, no auto-cycle
  logic       rst, btn, sw_direct, frame, lock;
  logic [1:0] sw_mode;
  logic [1:0] bg, state;
  logic       blank, pending, mc;

  // Instance B: BLANK_FRAMES=0, AUTO_PERIOD_FRAMES=3
  logic       b_rst, b_frame;
  logic [1:0] b_bg, b_state;
  logic       b_blank, b_pending, b_mc;

  video_mode_ctrl #(.BLANK_FRAMES(2), .AUTO_PERIOD_FRAMES(0)) dut (
    .clk_in(clk), .rst_in(rst), .btn_pulse_in(btn), .sw_direct_in(sw_direct),
    .sw_mode_in(sw_mode), .frame_start_in(frame), .camera_locked_in(lock),
    .bg_out(bg), .blank_out(blank), .pending_out(pending),
    .mode_changed_out(mc), .state_dbg(state)
  );

  video_mode_ctrl #(.BLANK_FRAMES(0), .AUTO_PERIOD_FRAMES(3)) dut_auto (
    .clk_in(clk), .rst_in(b_rst), .btn_pulse_in(1'b0), .sw_direct_in(1'b0),
    .sw_mode_in(2'd0), .frame_start_in(b_frame), .camera_locked_in(1'b1),
    .bg_out(b_bg), .blank_out(b_blank), .pending_out(b_pending),
    .mode_changed_out(b_mc), .state_dbg(b_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic pulse_btn();
    btn = 1'b1;
    tick();
    btn = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; btn = 1'b0; sw_direct = 1'b0; sw_mode = 2'd0; frame = 1'b0; lock = 1'b1;
    b_rst = 1'b1; b_frame = 1'b0;
    tick_n(2);
    chk("rst_bg", {2'b0, bg}, 4'd0);
    chk("rst_blank", {3'b0, blank}, 4'd0);
    chk("rst_pending", {3'b0, pending}, 4'd0);
    chk("rst_mc", {3'b0, mc}, 4'd0);
    chk("rst_state", {2'b0, state}, 4'd0);
    rst = 1'b0;
    tick();

    // Single button press, commit on next frame, two blanked frames
    pulse_btn();
    chk("t1_pending", {3'b0, pending}, 4'd1);
    chk("t1_bg_hold", {2'b0, bg}, 4'd0);
    tick_n(3);
    pulse_frame();
    chk("t1_bg", {2'b0, bg}, 4'd1);
    chk("t1_mc", {3'b0, mc}, 4'd1);
    chk("t1_blank", {3'b0, blank}, 4'd1);
    chk("t1_pend_clr", {3'b0, pending}, 4'd0);
    chk("t1_state", {2'b0, state}, 4'd2);
    tick();
    chk("t1_mc_once", {3'b0, mc}, 4'd0);
    tick_n(5);
    pulse_frame();
    chk("t1_blank_f1", {3'b0, blank}, 4'd1);
    tick_n(5);
    pulse_frame();
    chk("t1_blank_end", {3'b0, blank}, 4'd0);
    chk("t1_state_end", {2'b0, state}, 4'd0);
    chk("t1_bg_end", {2'b0, bg}, 4'd1);

    // Three presses from bg=1: target advances 2,3,0 from the latched target
    pulse_btn(); tick_n(2);
    pulse_btn(); tick_n(2);
    pulse_btn();
    chk("t2a_pending", {3'b0, pending}, 4'd1);
    chk("t2a_bg_hold", {2'b0, bg}, 4'd1);
    pulse_frame();
    chk("t2a_bg", {2'b0, bg}, 4'd0);
    chk("t2a_mc", {3'b0, mc}, 4'd1);
    tick();
    chk("t2a_mc_once", {3'b0, mc}, 4'd0);
    pulse_frame(); pulse_frame();

    // Three presses from bg=0: single commit to 3
    pulse_btn(); tick();
    pulse_btn(); tick();
    pulse_btn();
    pulse_frame();
    chk("t2b_bg", {2'b0, bg}, 4'd3);
    chk("t2b_mc", {3'b0, mc}, 4'd1);
    tick();
    chk("t2b_mc_once", {3'b0, mc}, 4'd0);
    pulse_frame(); pulse_frame();

    // Button coincident with frame in STABLE: latch only
    btn = 1'b1; frame = 1'b1;
    tick();
    btn = 1'b0; frame = 1'b0;
    chk("t3a_pending", {3'b0, pending}, 4'd1);
    chk("t3a_bg_hold", {2'b0, bg}, 4'd3);
    chk("t3a_mc", {3'b0, mc}, 4'd0);
    pulse_frame();
    chk("t3a_bg", {2'b0, bg}, 4'd0);
    pulse_frame(); pulse_frame();

    // Button coincident with frame in PENDING: commit old target, new one stays pending
    pulse_btn();
    btn = 1'b1; frame = 1'b1;
    tick();
    btn = 1'b0; frame = 1'b0;
    chk("t3b_bg", {2'b0, bg}, 4'd1);
    chk("t3b_mc", {3'b0, mc}, 4'd1);
    chk("t3b_pending", {3'b0, pending}, 4'd1);
    tick_n(2);
    pulse_frame();
    chk("t3b_blank_f1", {3'b0, blank}, 4'd1);
    tick_n(2);
    pulse_frame();
    chk("t3b_blank_end", {3'b0, blank}, 4'd0);
    chk("t3b_no_commit", {2'b0, bg}, 4'd1);
    chk("t3b_state_pend", {2'b0, state}, 4'd1);
    tick_n(2);
    pulse_frame();
    chk("t3b_bg2", {2'b0, bg}, 4'd2);
    chk("t3b_mc2", {3'b0, mc}, 4'd1);
    pulse_frame(); pulse_frame();

    // Lock loss at bg=2 forces staff mode
    lock = 1'b0;
    tick();
    chk("t4_pending", {3'b0, pending}, 4'd1);
    chk("t4_bg_hold", {2'b0, bg}, 4'd2);
    pulse_frame();
    chk("t4_bg", {2'b0, bg}, 4'd0);
    chk("t4_blank", {3'b0, blank}, 4'd1);
    pulse_frame(); pulse_frame();
    pulse_btn();
    chk("t4_btn_nolock", {3'b0, pending}, 4'd0);

    // Direct camera mode without lock waits for lock
    sw_direct = 1'b1; sw_mode = 2'd1;
    tick();
    chk("t4_dir_pending", {3'b0, pending}, 4'd1);
    pulse_frame();
    chk("t4_dir_wait", {2'b0, bg}, 4'd0);
    chk("t4_dir_wait_mc", {3'b0, mc}, 4'd0);
    lock = 1'b1;
    tick();
    pulse_frame();
    chk("t4_dir_bg", {2'b0, bg}, 4'd1);
    chk("t4_dir_mc", {3'b0, mc}, 4'd1);
    pulse_frame(); pulse_frame();
    pulse_btn();
    chk("t4_dir_btn_ign", {3'b0, pending}, 4'd0);

    // Reset during PENDING coincident with frame
    sw_direct = 1'b0;
    pulse_btn();
    chk("t5_pending", {3'b0, pending}, 4'd1);
    rst = 1'b1; frame = 1'b1;
    tick();
    rst = 1'b0; frame = 1'b0;
    chk("t5_bg", {2'b0, bg}, 4'd0);
    chk("t5_pending_clr", {3'b0, pending}, 4'd0);
    chk("t5_mc", {3'b0, mc}, 4'd0);
    chk("t5_blank", {3'b0, blank}, 4'd0);
    chk("t5_state", {2'b0, state}, 4'd0);

    // Auto-cycle: commits on frames 4, 8, 12, 16 giving 1, 2, 3, 0
    b_rst = 1'b1;
    tick_n(2);
    b_rst = 1'b0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      b_frame = 1'b1;
      tick();
      b_frame = 1'b0;
      chk($sformatf("auto_bg_f%0d", k), {2'b0, b_bg}, 4'((k / 4) % 4));
      chk($sformatf("auto_mc_f%0d", k), {3'b0, b_mc}, ((k % 4) == 0) ? 4'd1 : 4'd0);
      chk($sformatf("auto_pend_f%0d", k), {3'b0, b_pending}, ((k % 4) == 3) ? 4'd1 : 4'd0);
      chk($sformatf("auto_blank_f%0d", k), {3'b0, b_blank}, 4'd0);
      tick_n(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Frame-synchronous controller for the video output mux's `bg` select. It takes user mode requests (button, switches, optional auto-cycle) and commits mode changes only at frame boundaries. It inserts a configurable number of blanked frames after each change and falls back to staff mode when the camera stream drops. It sits between the user-input debouncers and the video mux, and drives the mux's `bg` input plus a force-black qualifier.

## Interface
Parameters:
- BLANK_FRAMES, 2: full frames forced black after each committed change; 0 disables blanking
- AUTO_PERIOD_FRAMES, 0: frames between automatic mode advances while stable; 0 disables auto-cycle

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous reset, active high
- btn_pulse_in  input  1  single-cycle debounced "next mode" request
- sw_direct_in  input  1  1 = mode taken from sw_mode_in; buttons and auto-cycle ignored
- sw_mode_in  input  2  direct mode select
- frame_start_in  input  1  single-cycle pulse at the first pixel of each frame
- camera_locked_in  input  1  camera pipeline delivering frames
- bg_out  output  2  committed mode to mux: 0 staff, 1/2 camera, 3 camera+mask+crosshair
- blank_out  output  1  force output black
- pending_out  output  1  a change is latched and not yet committed
- mode_changed_out  output  1  one-cycle pulse on each commit

## Operation
- Reset values: bg_out=0, blank_out=0, pending_out=0, mode_changed_out=0, state STABLE, target=0, all counters 0.
- States: STABLE, PENDING, BLANK.
- Target computation, manual/auto: next = (target_or_current+1) mod 4. If camera_locked_in=0, any next in 1..3 becomes 0.
- Target computation, direct: target = sw_mode_in whenever sw_mode_in != bg_out.
  - Camera modes with camera_locked_in=0 remain pending until lock, with no substitution.
- STABLE → PENDING: on btn_pulse_in, an auto-cycle expiry, or a direct mismatch. The target is latched and pending_out=1.
  - If the computed target equals bg_out, nothing happens.
- PENDING, further btn_pulse_in: advances target again from the latched target, not from bg_out.
- PENDING → commit: on frame_start_in (and lock satisfied for direct camera targets), the following all happen next cycle:
  - bg_out ← target
  - mode_changed_out=1 for 1 cycle
  - pending_out=0
  - If BLANK_FRAMES>0: blank_out=1 and state → BLANK; otherwise state → STABLE.
- BLANK: counts frame_start_in pulses. On the BLANK_FRAMES-th pulse, blank_out clears next cycle and state → STABLE, or → PENDING if a request arrived during BLANK.
  - Requests during BLANK are latched: target updated, pending_out=1.
  - They are not committed on the same frame_start that ends BLANK. The earliest commit is the following frame_start.
- Lock loss: camera_locked_in=0 while bg_out∈{1,2,3}, in any state, forces target=0 and PENDING. This overrides any latched camera target.
- Auto-cycle: frame counter runs only in STABLE with sw_direct_in=0. It resets on any request and on entry to STABLE. When it reaches AUTO_PERIOD_FRAMES it acts as btn_pulse_in.
- Toggling sw_direct_in: takes effect the next cycle and discards a pending manual target unless it matches direct evaluation.

## Timing
- Commit latency: bg_out, mode_changed_out and blank_out change exactly 1 cycle after the qualifying frame_start_in.
- bg_out never changes at any other time.
- Request latency: pending_out rises 1 cycle after btn_pulse_in, a switch change, or loss of lock.
- btn_pulse_in coincident with frame_start_in in STABLE: latched only; commit at the next frame_start_in.
- btn_pulse_in coincident with frame_start_in in PENDING: commit uses the pre-advance target; the advanced target stays pending.
- Blank duration: blank_out high from commit+1 until 1 cycle after the BLANK_FRAMES-th subsequent frame_start_in.
- rst_in mid-PENDING or mid-BLANK: all outputs and state return to reset values the next cycle; latched requests are lost.

## Test plan
- Reset, lock=1, BLANK_FRAMES=2: pulse btn, then frames at t=100,200,300. Expect:
  - pending_out=1 at btn+1
  - bg_out=1 and mode_changed_out pulse at 101
  - blank_out high 101..300, low at 301
- Three btn pulses before a frame_start from bg=0: single commit to bg_out=3 with one mode_changed_out pulse.
- bg_out=2, drop camera_locked_in: pending_out=1 next cycle; at next frame_start, bg_out=0 with blank. Then direct sw_mode_in=1 with lock=0 stays pending until lock returns and a frame_start occurs.
- btn during BLANK: no commit on the frame ending BLANK; commit on the following frame_start.
- AUTO_PERIOD_FRAMES=3, BLANK_FRAMES=0, lock=1: bg_out sequence 0→1→2→3→0, with each step 4 frame_starts after the previous commit.
- rst_in asserted during PENDING coincident with frame_start_in: bg_out=0 and pending_out=0 the next cycle, with no mode_changed_out pulse.
